dmem_bytelane: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_bytelane.sv | 89 ++++++++
 tb/tb_dmem_bytelane.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store byte-enable/data replication and load lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wd,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    misalign = (size == 2'b11) ||
               (size == SZ_HALF && a_lo[0]) ||
               (size == SZ_WORD && a_lo != 2'b00);
    b_sel = word[{a_lo, 3'b000} +: 8];
    h_sel = word[{a_lo[1], 4'b0000} +: 16];
    be    = 4'b0000;
    wdata = wd;
    rdata = '0;
    // Replicating the low lanes lets the byte enable alone pick the destination.
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << a_lo;
        wdata = {4{wd[7:0]}};
        rdata = unsigned_ld ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
      end
      SZ_HALF: begin
        be    = 4'b0011 << {a_lo[1], 1'b0};
        wdata = {2{wd[15:0]}};
        rdata = unsigned_ld ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        rdata = word;
      end
      default: ;
    endcase
    if (misalign) begin
      be    = 4'b0000;
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory: async read, sync byte-lane write, clear sweep after reset.
// Optional DMEM_TEST_PORT_EN exposes the low half of word TEST_ADDR on test_value.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int TEST_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              busy,
  output logic              misalign
`ifdef DMEM_TEST_PORT_EN
  ,
  output logic [15:0]       test_value
`endif
);

  localparam int IDX_W = clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [IDX_W-1:0] iw;
  logic [3:0]       be;
  logic [31:0]      wdata, rdata;
  logic             mis_raw;
  logic             unused_a_hi;

  assign iw          = a[IDX_W+1:2];
  assign unused_a_hi = ^a[ADDR_W-1:IDX_W+2];

  dmem_lane_align u_align (
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .a_lo        (a[1:0]),
    .wd          (wd),
    .word        (mem[iw]),
    .be          (be),
    .wdata       (wdata),
    .rdata       (rdata),
    .misalign    (mis_raw)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // The array has no reset; the sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (we) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[iw][l*8 +: 8] <= wdata[l*8 +: 8];
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign misalign = !busy && mis_raw;
  assign rd       = busy ? 32'h0 : rdata;

`ifdef DMEM_TEST_PORT_EN
  assign test_value = busy ? 16'h0 : mem[TEST_ADDR][15:0];
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Randomized bench for dmem_bytelane against a byte-array reference model.
module tb_dmem_bytelane;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        we = 0;
  logic [1:0]  size = 2'b10;
  logic        unsigned_ld = 0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        busy, misalign;
`ifdef DMEM_TEST_PORT_EN
  logic [15:0] test_value;
`endif

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] model [NB];

  always #5 clk = ~clk;

  dmem_bytelane #(.ADDR_W(32), .DEPTH(DEPTH), .TEST_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .a(a), .wd(wd), .rd(rd), .busy(busy), .misalign(misalign)
`ifdef DMEM_TEST_PORT_EN
    , .test_value(test_value)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic ref_mis(input logic [31:0] ad, input logic [1:0] sz);
    return (sz == 3) || (sz == 1 && ad % 2 != 0) || (sz == 2 && ad % 4 != 0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_ld(input logic [31:0] ad, input logic [1:0] sz, input logic uns);
    int base, n;
    logic [31:0] v;
    if (ref_mis(ad, sz)) return 0;
    base = int'(ad % NB);
    n = nbytes(sz);
    v = 0;
    for (int k = 0; k < n; k++) v = v + (32'(model[base + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NB; i++) model[i] = 8'h00;
  endtask

  task automatic st(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] d);
    logic m;
    @(negedge clk);
    we = 1; a = ad; size = sz; wd = d;
    #1;
    m = ref_mis(ad, sz);
    chk("st_mis", 32'(misalign), 32'(m));
    if (m) chk("st_mis_rd", rd, 0);
    @(posedge clk);
    if (!m)
      for (int k = 0; k < nbytes(sz); k++) model[int'((ad + k) % NB)] = d[8*k +: 8];
    #1 we = 0;
  endtask

  task automatic ld(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                    input logic uns, output logic [31:0] got);
    @(negedge clk);
    we = 0; a = ad; size = sz; unsigned_ld = uns;
    #1;
    got = rd;
    chk(tag, rd, ref_ld(ad, sz, uns));
    chk({tag, "_mis"}, 32'(misalign), 32'(ref_mis(ad, sz)));
  endtask

  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (busy && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic scan_zero(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      we = 0; size = 2'b10; a = 32'(i * 4);
      #1;
      if (rd !== 32'h0) bad++;
    end
    chk(tag, 32'(bad), 0);
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    clear_model();

    #12;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_rd", rd, 0);
    chk("rst_mis", 32'(misalign), 0);
`ifdef DMEM_TEST_PORT_EN
    chk("rst_tv", 32'(test_value), 0);
`endif
    @(negedge clk); rst_n = 1;
    wait_sweep(cnt);
    chk("sweep_len", 32'(cnt), 256);
    chk("ready_busy", 32'(busy), 0);
    scan_zero("init_zero");

    st(32'h10, 2'b10, 32'h8899AABB);
    st(32'h12, 2'b00, 32'h00000011);
    ld("lw10", 32'h10, 2'b10, 0, r);  chk("lw10_k", r, 32'h8811AABB);
    ld("lb13", 32'h13, 2'b00, 0, r);  chk("lb13_k", r, 32'hFFFFFF88);
    ld("lbu13", 32'h13, 2'b00, 1, r); chk("lbu13_k", r, 32'h00000088);

    st(32'h22, 2'b01, 32'h00008001);
    ld("lh22", 32'h22, 2'b01, 0, r);  chk("lh22_k", r, 32'hFFFF8001);
    ld("lhu22", 32'h22, 2'b01, 1, r); chk("lhu22_k", r, 32'h00008001);
    ld("lw20", 32'h20, 2'b10, 0, r);  chk("lw20_k", r, 32'h80010000);

    st(32'h06, 2'b10, 32'hFFFFFFFF);
    st(32'h05, 2'b01, 32'hFFFFFFFF);
    st(32'h04, 2'b11, 32'hFFFFFFFF);
    ld("lw04", 32'h04, 2'b10, 0, r);  chk("lw04_k", r, 32'h0);
    ld("ld_sz11", 32'h10, 2'b11, 0, r); chk("sz11_k", r, 32'h0);

    st(32'h400, 2'b10, 32'hDEADBEEF);
    ld("alias", 32'h000, 2'b10, 0, r); chk("alias_k", r, 32'hDEADBEEF);
`ifdef DMEM_TEST_PORT_EN
    #1 chk("tv_alias", 32'(test_value), 32'hBEEF);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      ad = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) st(ad, sz, $urandom);
      else ld("rnd", ad, sz, 1'($urandom_range(0, 1)), r);
    end

    // Re-run the sweep over a dirty array.
    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 2'b10, $urandom | 32'h1);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    clear_model();
    wait_sweep(cnt);
    chk("resweep_len", 32'(cnt), 256);
    scan_zero("resweep_zero");

    // Reset pulsed at clr_idx == 100; CPU stores held active throughout.
    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 2'b10, 32'hA5A5A5A5);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    clear_model();
    we = 1; wd = 32'hFFFFFFFF; size = 2'b10; a = 32'h40;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_rd", rd, 0);
    size = 2'b11; #1;
    chk("mid_mis", 32'(misalign), 0);
    size = 2'b10;
    @(negedge clk); rst_n = 0;
    #1 chk("mid_rst_busy", 32'(busy), 1);
    @(negedge clk); rst_n = 1;
    wait_sweep(cnt);
    we = 0;
    chk("mid_sweep_len", 32'(cnt), 256);
    scan_zero("mid_zero");
    ld("post_lw40", 32'h40, 2'b10, 0, r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
